// File: rtl/uart_rx_fifo_display.sv
// UART receiver feeding a FIFO; each debounced button press pops one byte to the LEDs and echoes it on TX.
// Optional feature macro: UART_PARITY_EN adds an even parity bit to both RX and TX frames.
module uart_rx_fifo_display #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned BAUD            = 115_200,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data,
  input  logic                          read_button,
  output logic                          tx_dataout,
  output logic                          busy,
  output logic [DATA_BITS-1:0]          D_LED,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err
);
  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int unsigned CW = $clog2(BIT_CYCLES + 1);
  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [NW-1:0] FULL      = NW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_WAIT
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  logic                 rx_s1, rx_s2, rx_s3, btn_s1, btn_s2;
  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_ok;
  logic                 push;
  logic [DATA_BITS-1:0] push_data;
  logic                 db_level;
  logic [DW-1:0]        db_cnt;
  logic                 read_pulse;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 pop, wr_en;
  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
`ifdef UART_PARITY_EN
  logic                 rx_par, tx_par;
  assign rx_par_ok = ((^rx_shift) == rx_par);
`else
  assign rx_par_ok = 1'b1;
`endif

  // Two-stage synchronisers; rx_s3 is the delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      {rx_s1, rx_s2, rx_s3, btn_s1, btn_s2} <= '1;
    end else begin
      rx_s1  <= data;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
      btn_s1 <= read_button;
      btn_s2 <= btn_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par    <= 1'b0;
`endif
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_s3 && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + 1'b1;
`ifdef UART_PARITY_EN
            if (rx_idx == IDX_LAST) rx_state <= RX_PARITY;
`else
            if (rx_idx == IDX_LAST) rx_state <= RX_STOP;
`endif
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_par   <= rx_s2;
            rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s2 && rx_par_ok) begin
              push      <= 1'b1;
              push_data <= rx_shift;
              rx_state  <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= rx_s2 ? RX_IDLE : RX_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Debounced level changes only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      db_level   <= 1'b1;
      db_cnt     <= '0;
      read_pulse <= 1'b0;
    end else begin
      read_pulse <= 1'b0;
      if (btn_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DEB_LAST) begin
        db_cnt     <= '0;
        db_level   <= btn_s2;
        read_pulse <= !btn_s2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign pop   = read_pulse && (fifo_count != '0) && !busy;
  assign wr_en = push && (pop || (fifo_count != FULL));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
      D_LED      <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop && (fifo_count == FULL)) overrun <= 1'b1;
      if (pop) begin
        D_LED  <= head;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop)     fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // TX echo; the start bit is driven on the same edge that pops the byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_idx     <= '0;
      tx_shift   <= '0;
      tx_dataout <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par     <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (pop) begin
            tx_shift   <= head;
            tx_dataout <= 1'b0;
            busy       <= 1'b1;
            tx_state   <= TX_START;
`ifdef UART_PARITY_EN
            tx_par     <= ^head;
`endif
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_dataout <= tx_shift[0];
            tx_shift   <= tx_shift >> 1;
            tx_state   <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
              tx_dataout <= tx_par;
              tx_state   <= TX_PARITY;
`else
              tx_dataout <= 1'b1;
              tx_state   <= TX_STOP;
`endif
            end else begin
              tx_dataout <= tx_shift[0];
              tx_shift   <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt     <= '0;
            tx_dataout <= 1'b1;
            tx_state   <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            busy     <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo_display.sv
// Bench for uart_rx_fifo_display: queue model of the FIFO, LED and overrun state plus an independent TX frame decoder.
module tb_uart_rx_fifo_display;
  localparam int unsigned BC    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DEB   = 20;
`ifdef UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data = 1'b1;
  logic       read_button = 1'b1;
  logic       tx_dataout, busy, overrun, frame_err;
  logic [7:0] D_LED;
  logic [2:0] fifo_count;

  uart_rx_fifo_display #(
    .CLK_FREQ(160), .BAUD(10), .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .read_button(read_button),
    .tx_dataout(tx_dataout), .busy(busy), .D_LED(D_LED),
    .fifo_count(fifo_count), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         ferr_cnt = 0;
  logic [7:0] mq[$];
  logic [7:0] echo_q[$];
  logic [7:0] m_led = 8'h00;
  logic       m_ovr = 1'b0;
  bit         settled = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model state is only compared once stimulus has let the DUT settle.
  always @(negedge clk) begin
    if (settled) begin
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("D_LED", 32'(D_LED), 32'(m_led));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (busy !== 1'b1) chk("tx_idle_high", 32'(tx_dataout), 32'h1);
    end
    if (frame_err === 1'b1) ferr_cnt++;
  end

  initial begin : tx_mon
    int         len;
    logic [10:0] bits;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        len  = 0;
        bits = '1;
        while (busy === 1'b1 && len < 400) begin
          if ((len % BC) == BC / 2 && (len / BC) < 11) bits[4'(len / BC)] = tx_dataout;
          len++;
          @(negedge clk);
        end
        chk("busy_len", 32'(len), 32'(NBITS * BC));
        chk("tx_start_bit", 32'(bits[0]), 32'h0);
        chk("tx_stop_bit", 32'(bits[NBITS-1]), 32'h1);
        if (echo_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_echo: got frame %0h expected no frame", bits[8:1]);
        end else begin
          exp = echo_q.pop_front();
          chk("tx_echo", 32'(bits[8:1]), 32'(exp));
`ifdef UART_PARITY_EN
          chk("tx_parity", 32'(bits[9]), 32'(^exp));
`endif
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    data = 1'b0;
    wait_cyc(BC);
    for (int i = 0; i < 8; i++) begin
      data = b[i];
      wait_cyc(BC);
    end
`ifdef UART_PARITY_EN
    data = ^b;
    wait_cyc(BC);
`endif
    settled = 1'b0;
    data = stop_bit;
    wait_cyc(BC);
    data = 1'b1;
    if (stop_bit) begin
      if (mq.size() < int'(DEPTH)) mq.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      wait_cyc(BC);
    end
    settled = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", 32'(busy), 32'h0);
  endtask

  task automatic press();
    settled = 1'b0;
    read_button = 1'b0;
    wait_cyc(40);
    if (mq.size() != 0) begin
      m_led = mq.pop_front();
      echo_q.push_back(m_led);
    end
    settled = 1'b1;
    read_button = 1'b1;
    wait_cyc(40);
    wait_idle();
  endtask

  initial begin
    reset = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(1);
    chk("rst_tx", 32'(tx_dataout), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_led", 32'(D_LED), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    settled = 1'b1;

    send_frame(8'h1F, 1'b1);
    wait_cyc(BC);
    chk("rx_1f_count", 32'(fifo_count), 32'h1);
    chk("rx_1f_led", 32'(D_LED), 32'h0);
    chk("rx_1f_ferr", 32'(ferr_cnt), 32'h0);

    send_frame(8'hA5, 1'b1);
    send_frame(8'hBD, 1'b1);
    send_frame(8'hBD, 1'b1);
    wait_cyc(4);
    chk("full_count", 32'(fifo_count), 32'h4);
    chk("full_no_overrun", 32'(overrun), 32'h0);

    press();
    chk("pop1_led", 32'(D_LED), 32'h1F);
    press();
    chk("pop2_led", 32'(D_LED), 32'hA5);
    press();
    chk("pop3_led", 32'(D_LED), 32'hBD);
    chk("pop3_count", 32'(fifo_count), 32'h1);

    // Short low pulse on the line is rejected at the half-bit resample.
    data = 1'b0;
    wait_cyc(3);
    data = 1'b1;
    wait_cyc(3 * BC);
    chk("glitch_count", 32'(fifo_count), 32'h1);
    chk("glitch_ferr", 32'(ferr_cnt), 32'h0);

    send_frame(8'h55, 1'b0);
    chk("badstop_ferr", 32'(ferr_cnt), 32'h1);
    chk("badstop_count", 32'(fifo_count), 32'h1);
    send_frame(8'h3C, 1'b1);
    chk("after_err_count", 32'(fifo_count), 32'h2);

    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    wait_cyc(4);
    chk("ovr_count", 32'(fifo_count), 32'h4);
    chk("ovr_flag", 32'(overrun), 32'h1);

    repeat (4) press();
    chk("drain_led", 32'(D_LED), 32'h02);
    chk("drain_count", 32'(fifo_count), 32'h0);

    press();
    chk("empty_led", 32'(D_LED), 32'h02);
    chk("empty_busy", 32'(busy), 32'h0);
    chk("empty_tx", 32'(tx_dataout), 32'h1);

    send_frame(8'h77, 1'b1);
    for (int i = 0; i < 20; i++) begin
      read_button = ~read_button;
      wait_cyc(3);
    end
    press();
    chk("bounce_led", 32'(D_LED), 32'h77);
    chk("bounce_count", 32'(fifo_count), 32'h0);

    wait_cyc(20);
    chk("echo_all_seen", 32'(echo_q.size()), 32'h0);
    chk("ferr_total", 32'(ferr_cnt), 32'h1);
    chk("overrun_sticky", 32'(overrun), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo_display.md
# uart_rx_fifo_display

Parametrised UART receive/playback block: deserialises bytes on the serial input, queues them in a FIFO, and on each debounced press of the read button pops one byte to the LED bank and echoes it on the serial output. It is the generalised successor of the single-byte receive/display design: configurable baud, data width, FIFO depth and debounce time, with status outputs for occupancy, overrun and framing errors. It sits between the board's UART pins, the push button and the LED bank.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz
- BAUD, 115_200, serial bit rate; BIT_CYCLES = CLK_FREQ/BAUD (434 at defaults), integer-truncated
- DATA_BITS, 8, bits per character (5..9)
- FIFO_DEPTH, 16, queue entries; power of two, at least 2
- DEBOUNCE_CYCLES, 50_000, clocks the button must be stable (1 ms at defaults)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- data  in  1  serial RX line, idle high, asynchronous to clk
- read_button  in  1  push button, active-low (pressed = 0), asynchronous, bouncy
- tx_dataout  out  1  serial TX echo, idle high
- busy  out  1  TX frame in progress
- D_LED  out  DATA_BITS  last byte popped
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries held
- overrun  out  1  sticky; set when a byte arrives while the FIFO is full
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low

## Operation
- Reset values: tx_dataout=1, busy=0, D_LED=0, fifo_count=0, overrun=0, frame_err=0. RX and TX state machines go to IDLE and the debouncer to the released state. Reset in mid-frame aborts the frame; the FIFO contents are lost.
- data and read_button each pass through a 2-FF synchroniser before use.
- RX FSM: IDLE -> START on a synchronised falling edge. START counts BIT_CYCLES/2 and resamples the line; if it is high again the event is a glitch and the FSM returns to IDLE, otherwise it goes to DATA. DATA samples DATA_BITS bits LSB first, every BIT_CYCLES. Then PARITY (macro only), then STOP.
- STOP with the line high: the byte is pushed into the FIFO. STOP with the line low: the byte is discarded, frame_err pulses, and the FSM waits for the line to go high before IDLE.
- Push while full: the byte is dropped and overrun is set; it clears only on reset.
- Debouncer: the synchronised button state must hold for DEBOUNCE_CYCLES consecutive clocks before the debounced level changes. A released-to-pressed transition produces a one-cycle read pulse. Holding the button produces no repeat pulses.
- Read pulse with the FIFO non-empty and busy=0: pop the head byte, load it into D_LED, and start a TX frame.
- Read pulse with the FIFO empty, or while busy=1: ignored. D_LED holds and the FIFO is unchanged.
- TX FSM: IDLE -> START -> DATA (LSB first) -> PARITY (macro only) -> STOP -> IDLE. Each state lasts BIT_CYCLES. busy is high from the cycle after the pop through the last stop-bit cycle.
- Simultaneous push and pop: both take effect and fifo_count is unchanged; this also holds when the FIFO is full. Push with a pop on an empty FIFO: only the push occurs.
- FIFO pointers are clog2(FIFO_DEPTH) bits wide and wrap naturally. fifo_count saturates at FIFO_DEPTH.

## Timing
- RX sample points fall at BIT_CYCLES/2 + k*BIT_CYCLES after the start edge, within ±2 clocks for synchronisation.
- Push happens 1 clock after the stop-bit sample, so fifo_count increments within about half a bit time of the stop bit starting.
- Press to read pulse: 2 synchroniser clocks + DEBOUNCE_CYCLES.
- Read pulse to pop and D_LED update: 1 clock. tx_dataout drops to the start bit in that same clock.
- TX frame length: (2 + DATA_BITS [+1 with parity]) * BIT_CYCLES clocks. busy falls after the last stop-bit clock.

## Configuration
- UART_PARITY_EN defined: even parity bit after the data bits on both RX and TX. An RX parity mismatch discards the byte and pulses frame_err (the shared error output). TX appends even parity.
- UART_PARITY_EN undefined: no parity bit; the frame is start + data + stop. The PARITY states and logic are not compiled.

## Test plan
- Reset low for 1 clk, then release -> all outputs at reset values; tx_dataout=1 held.
- RX frame for 0x1F at 8680 ns/bit (bits 1,1,1,1,1,0,0,0) -> fifo_count=1, frame_err stays 0, D_LED still 0x00.
- Send 0x1F, 0xA5, 0xBD, 0xBD back-to-back, then press for 2 ms three times, ≥100 ms apart -> D_LED shows 0x1F, then 0xA5, then 0xBD. Each TX echo is bit-exact, busy is high for 10*434 clocks per echo, and fifo_count ends at 1.
- 17 frames into the 16-deep FIFO with no reads -> fifo_count=16, overrun=1. After 16 presses the bytes come out as the first 16 sent.
- Stop bit forced low on an RX frame -> frame_err pulses once, fifo_count unchanged. The next valid frame is received normally.
- Button bouncing with 5 µs pulses for 500 µs, then a steady press -> exactly one pop. A press on an empty FIFO -> D_LED unchanged, tx_dataout stays 1.
